router_ctrl: RTL and testbench

ROUTER_CTRL -- requirements
Module: router_ctrl

---
 rtl/router_ctrl_if.sv | 36 +++
 rtl/router_ctrl.sv | 143 ++++++++++++++
 tb/tb_router_ctrl.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/router_ctrl_if.sv
// Bundles the router controller's packet/FIFO handshake signals.
// The master modport belongs to the packet source/FIFO side, the slave modport to router_ctrl.
interface router_ctrl_if;
    logic       pkt_valid;
    logic [1:0] addr_in;
    logic [2:0] full;
    logic [2:0] empty;
    logic [2:0] read_enb;
    logic       parity_done;
    logic       low_pkt_valid;

    logic [2:0] write_enb;
    logic [2:0] soft_reset;
    logic [2:0] vld_out;
    logic       fifo_full;
    logic       busy;
    logic       detect_add;
    logic       lfd_state;
    logic       ld_state;
    logic       laf_state;
    logic       full_state;
    logic       write_enb_reg;
    logic       rst_int_reg;

    modport master (
        output pkt_valid, addr_in, full, empty, read_enb, parity_done, low_pkt_valid,
        input  write_enb, soft_reset, vld_out, fifo_full, busy, detect_add,
               lfd_state, ld_state, laf_state, full_state, write_enb_reg, rst_int_reg
    );

    modport slave (
        input  pkt_valid, addr_in, full, empty, read_enb, parity_done, low_pkt_valid,
        output write_enb, soft_reset, vld_out, fifo_full, busy, detect_add,
               lfd_state, ld_state, laf_state, full_state, write_enb_reg, rst_int_reg
    );
endinterface

// File: rtl/router_ctrl.sv
// Router control FSM: steers one packet at a time into one of three output FIFOs and
// flushes any FIFO whose data has gone unread for SOFT_RST_CYCLES consecutive cycles.
module router_ctrl #(
    parameter int SOFT_RST_CYCLES = 30
) (
    input logic          clk,
    input logic          resetn,
    router_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        DECODE_ADDRESS,
        LOAD_FIRST_DATA,
        LOAD_DATA,
        LOAD_PARITY,
        FIFO_FULL_STATE,
        LOAD_AFTER_FULL,
        WAIT_TILL_EMPTY,
        CHECK_PARITY_ERROR
    } state_e;

    localparam logic [4:0] TIMER_LAST = 5'(SOFT_RST_CYCLES - 1);

    state_e     state_q, state_d;
    logic [1:0] addr_q, addr_d;
    logic [4:0] timer_q [3];
    logic [2:0] soft_reset_q;
    logic [2:0] vld_w;
    logic       fifo_full_w;

    assign vld_w       = ~bus.empty;
    assign fifo_full_w = bus.full[addr_q];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= DECODE_ADDRESS;
            addr_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        case (state_q)
            DECODE_ADDRESS: begin
                if (bus.pkt_valid && (bus.addr_in != 2'd3)) begin
                    addr_d  = bus.addr_in;
                    state_d = bus.empty[bus.addr_in] ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
                end
            end
            LOAD_FIRST_DATA: state_d = LOAD_DATA;
            LOAD_DATA: begin
                if (fifo_full_w)         state_d = FIFO_FULL_STATE;
                else if (!bus.pkt_valid) state_d = LOAD_PARITY;
            end
            LOAD_PARITY: state_d = CHECK_PARITY_ERROR;
            CHECK_PARITY_ERROR: state_d = fifo_full_w ? FIFO_FULL_STATE : DECODE_ADDRESS;
            FIFO_FULL_STATE: begin
                if (!fifo_full_w) state_d = LOAD_AFTER_FULL;
            end
            LOAD_AFTER_FULL: begin
                if (bus.parity_done)        state_d = DECODE_ADDRESS;
                else if (bus.low_pkt_valid) state_d = LOAD_PARITY;
                else                        state_d = LOAD_DATA;
            end
            WAIT_TILL_EMPTY: begin
                if (bus.empty[addr_q]) state_d = LOAD_FIRST_DATA;
            end
            default: state_d = DECODE_ADDRESS;
        endcase
        // A flush of the FIFO we are feeding abandons the packet in progress.
        if ((state_q != DECODE_ADDRESS) && soft_reset_q[addr_q]) begin
            state_d = DECODE_ADDRESS;
        end
    end

    always_comb begin
        bus.detect_add    = 1'b0;
        bus.lfd_state     = 1'b0;
        bus.ld_state      = 1'b0;
        bus.laf_state     = 1'b0;
        bus.full_state    = 1'b0;
        bus.rst_int_reg   = 1'b0;
        bus.write_enb_reg = 1'b0;
        bus.busy          = 1'b1;
        case (state_q)
            DECODE_ADDRESS: begin
                bus.detect_add = 1'b1;
                bus.busy       = 1'b0;
            end
            LOAD_FIRST_DATA: begin
                bus.lfd_state     = 1'b1;
                bus.write_enb_reg = 1'b1;
            end
            LOAD_DATA: begin
                bus.ld_state      = 1'b1;
                bus.write_enb_reg = 1'b1;
                bus.busy          = 1'b0;
            end
            LOAD_PARITY:        bus.write_enb_reg = 1'b1;
            FIFO_FULL_STATE:    bus.full_state    = 1'b1;
            LOAD_AFTER_FULL: begin
                bus.laf_state     = 1'b1;
                bus.write_enb_reg = 1'b1;
            end
            CHECK_PARITY_ERROR: bus.rst_int_reg   = 1'b1;
            default: ;
        endcase
        bus.write_enb  = bus.write_enb_reg ? (3'b001 << addr_q) : 3'b000;
        bus.fifo_full  = fifo_full_w;
        bus.vld_out    = vld_w;
        bus.soft_reset = soft_reset_q;
    end

    // Each timer counts consecutive cycles of unread data; the flush pulse follows the last one.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            soft_reset_q <= 3'b000;
            for (int n = 0; n < 3; n++) begin
                timer_q[n] <= 5'd0;
            end
        end else begin
            for (int n = 0; n < 3; n++) begin
                if (vld_w[n] && !bus.read_enb[n]) begin
                    if (timer_q[n] == TIMER_LAST) begin
                        timer_q[n]      <= 5'd0;
                        soft_reset_q[n] <= 1'b1;
                    end else begin
                        timer_q[n]      <= timer_q[n] + 5'd1;
                        soft_reset_q[n] <= 1'b0;
                    end
                end else begin
                    timer_q[n]      <= 5'd0;
                    soft_reset_q[n] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_router_ctrl.sv
// Self-checking bench for router_ctrl: directed packet scenarios followed by random traffic,
// all compared against a behavioural model of the routing rules.
module tb_router_ctrl;

    localparam int SOFT = 30;

    logic clk = 1'b0;
    logic resetn = 1'b1;
    int   checks = 0;
    int   errors = 0;

    router_ctrl_if bus ();

    router_ctrl #(.SOFT_RST_CYCLES(SOFT)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    // Reference model: named states, packet destination and unread-cycle counters.
    string      mState;
    logic [1:0] mAddr;
    int         mUnread [3];
    logic [2:0] mSoft;

    task automatic modelReset();
        mState = "DECODE";
        mAddr  = 2'd0;
        mSoft  = 3'b000;
        for (int n = 0; n < 3; n++) mUnread[n] = 0;
    endtask

    task automatic modelStep();
        string      ns;
        logic [1:0] na;
        logic       ff;
        logic [2:0] nsoft;
        if (!resetn) begin
            modelReset();
            return;
        end
        ns = mState;
        na = mAddr;
        ff = bus.full[mAddr];
        if (mState == "DECODE") begin
            if (bus.pkt_valid && bus.addr_in != 2'd3) begin
                na = bus.addr_in;
                if (bus.empty[bus.addr_in]) ns = "LFD";
                else ns = "WAIT";
            end
        end else if (mState == "LFD") ns = "LD";
        else if (mState == "LD") begin
            if (ff) ns = "FULL";
            else if (!bus.pkt_valid) ns = "LP";
        end else if (mState == "LP") ns = "CPE";
        else if (mState == "CPE") begin
            if (ff) ns = "FULL";
            else ns = "DECODE";
        end else if (mState == "FULL") begin
            if (!ff) ns = "LAF";
        end else if (mState == "LAF") begin
            if (bus.parity_done) ns = "DECODE";
            else if (bus.low_pkt_valid) ns = "LP";
            else ns = "LD";
        end else if (mState == "WAIT") begin
            if (bus.empty[mAddr]) ns = "LFD";
        end
        if (mState != "DECODE" && mSoft[mAddr]) ns = "DECODE";
        nsoft = 3'b000;
        for (int n = 0; n < 3; n++) begin
            if (!bus.empty[n] && !bus.read_enb[n]) begin
                mUnread[n]++;
                if (mUnread[n] == SOFT) begin
                    nsoft[n]   = 1'b1;
                    mUnread[n] = 0;
                end
            end else begin
                mUnread[n] = 0;
            end
        end
        mState = ns;
        mAddr  = na;
        mSoft  = nsoft;
    endtask

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b (model state %s)", tag, got, exp, mState);
        end
    endtask

    task automatic checkOutput();
        logic       wreg;
        logic       bsy;
        logic [7:0] expStrobe;
        logic [7:0] gotStrobe;
        wreg = (mState == "LFD") || (mState == "LD") || (mState == "LP") || (mState == "LAF");
        bsy  = !((mState == "DECODE") || (mState == "LD"));
        expStrobe = {mState == "DECODE", mState == "LFD", mState == "LD", mState == "LAF",
                     mState == "FULL", wreg, mState == "CPE", bsy};
        gotStrobe = {bus.detect_add, bus.lfd_state, bus.ld_state, bus.laf_state,
                     bus.full_state, bus.write_enb_reg, bus.rst_int_reg, bus.busy};
        check("strobes", gotStrobe, expStrobe);
        check("write_enb", {5'd0, bus.write_enb}, wreg ? {5'd0, 3'b001 << mAddr} : 8'd0);
        check("soft_reset", {5'd0, bus.soft_reset}, {5'd0, mSoft});
        check("vld_out", {5'd0, bus.vld_out}, {5'd0, ~bus.empty});
        check("fifo_full", {7'd0, bus.fifo_full}, {7'd0, bus.full[mAddr]});
    endtask

    // Drives one cycle of inputs, checks before the edge, then advances the model on the edge.
    task automatic applyStimulus(input logic pv, input logic [1:0] ad, input logic [2:0] fu,
                                 input logic [2:0] em, input logic [2:0] re,
                                 input logic pd, input logic lpv);
        bus.pkt_valid     = pv;
        bus.addr_in       = ad;
        bus.full          = fu;
        bus.empty         = em;
        bus.read_enb      = re;
        bus.parity_done   = pd;
        bus.low_pkt_valid = lpv;
        #1 checkOutput();
        @(posedge clk);
        modelStep();
        @(negedge clk);
    endtask

    initial begin
        int         weCount;
        logic [2:0] emp;
        logic [2:0] ful;
        logic [2:0] rd;

        modelReset();
        bus.pkt_valid = 0; bus.addr_in = 0; bus.full = 0; bus.empty = 3'b111;
        bus.read_enb = 0; bus.parity_done = 0; bus.low_pkt_valid = 0;
        #2 resetn = 1'b0;
        @(negedge clk);
        applyStimulus(1, 2'd1, 3'b000, 3'b111, 3'b000, 0, 0);
        applyStimulus(1, 2'd1, 3'b000, 3'b111, 3'b000, 0, 0);
        resetn = 1'b1;

        // Four-byte packet into empty FIFO 1.
        weCount = 0;
        applyStimulus(1, 2'd1, 3'b000, 3'b111, 3'b000, 0, 0);
        weCount += int'(bus.write_enb === 3'b010);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 2'd1, 3'b000, 3'b111, 3'b000, 0, 0);
            weCount += int'(bus.write_enb === 3'b010);
        end
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 2'd1, 3'b000, 3'b111, 3'b000, 0, 0);
            weCount += int'(bus.write_enb === 3'b010);
        end
        check("write_cycles_fifo1", 8'(weCount), 8'd6);
        check("back_to_decode", {7'd0, bus.detect_add}, 8'd1);

        // FIFO 2 fills mid-payload, then drains.
        applyStimulus(1, 2'd2, 3'b000, 3'b111, 3'b000, 0, 0);
        applyStimulus(1, 2'd2, 3'b000, 3'b111, 3'b000, 0, 0);
        applyStimulus(1, 2'd2, 3'b000, 3'b111, 3'b000, 0, 0);
        applyStimulus(1, 2'd2, 3'b100, 3'b111, 3'b000, 0, 0);
        check("full_state_busy_we", {bus.full_state, bus.busy, 3'b000, bus.write_enb}, 8'b1100_0000);
        applyStimulus(1, 2'd2, 3'b100, 3'b111, 3'b000, 0, 0);
        applyStimulus(1, 2'd2, 3'b000, 3'b111, 3'b000, 0, 0);
        check("laf_entered", {7'd0, bus.laf_state}, 8'd1);
        applyStimulus(1, 2'd2, 3'b000, 3'b111, 3'b000, 0, 0);
        check("laf_to_ld", {7'd0, bus.ld_state}, 8'd1);
        for (int i = 0; i < 3; i++) applyStimulus(0, 2'd2, 3'b000, 3'b111, 3'b000, 0, 0);

        // Header for non-empty FIFO 0 waits until it drains.
        applyStimulus(1, 2'd0, 3'b000, 3'b110, 3'b001, 0, 0);
        applyStimulus(1, 2'd0, 3'b000, 3'b110, 3'b001, 0, 0);
        check("wait_busy", {6'd0, bus.busy, bus.detect_add}, 8'b10);
        applyStimulus(1, 2'd0, 3'b000, 3'b111, 3'b000, 0, 0);
        check("wait_to_lfd", {7'd0, bus.lfd_state}, 8'd1);
        for (int i = 0; i < 4; i++) applyStimulus(0, 2'd0, 3'b000, 3'b111, 3'b000, 0, 0);

        // Invalid destination is ignored.
        for (int i = 0; i < 3; i++) applyStimulus(1, 2'd3, 3'b000, 3'b111, 3'b000, 0, 0);
        check("addr3_ignored", {bus.detect_add, 4'd0, bus.write_enb}, 8'b1000_0000);

        // Unread FIFO 0 flushes after SOFT cycles; a read on cycle SOFT-1 prevents it.
        for (int i = 0; i < SOFT; i++) applyStimulus(0, 2'd0, 3'b000, 3'b110, 3'b000, 0, 0);
        check("soft_reset_pulse", {5'd0, bus.soft_reset}, 8'b001);
        applyStimulus(0, 2'd0, 3'b000, 3'b110, 3'b000, 0, 0);
        check("soft_reset_one_cycle", {5'd0, bus.soft_reset}, 8'd0);
        applyStimulus(0, 2'd0, 3'b000, 3'b110, 3'b001, 0, 0);
        for (int i = 0; i < SOFT - 2; i++) applyStimulus(0, 2'd0, 3'b000, 3'b110, 3'b000, 0, 0);
        applyStimulus(0, 2'd0, 3'b000, 3'b110, 3'b001, 0, 0);
        for (int i = 0; i < 3; i++) applyStimulus(0, 2'd0, 3'b000, 3'b110, 3'b000, 0, 0);
        check("read_blocks_pulse", {5'd0, bus.soft_reset}, 8'd0);
        applyStimulus(0, 2'd0, 3'b000, 3'b111, 3'b000, 0, 0);

        // Asynchronous reset in the middle of LOAD_DATA.
        applyStimulus(1, 2'd1, 3'b000, 3'b111, 3'b000, 0, 0);
        applyStimulus(1, 2'd1, 3'b000, 3'b111, 3'b000, 0, 0);
        check("in_load_data", {7'd0, bus.ld_state}, 8'd1);
        #3 resetn = 1'b0;
        #1 check("async_reset", {bus.detect_add, bus.busy, bus.ld_state, 2'd0, bus.write_enb}, 8'b1000_0000);
        modelReset();
        @(negedge clk);
        applyStimulus(1, 2'd1, 3'b000, 3'b111, 3'b000, 0, 0);
        resetn = 1'b1;

        // Random traffic against the model.
        emp = 3'b111;
        ful = 3'b000;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(15) == 0) emp[$urandom_range(2)] ^= 1'b1;
            if ($urandom_range(9) == 0)  ful[$urandom_range(2)] ^= 1'b1;
            for (int n = 0; n < 3; n++) rd[n] = ($urandom_range(39) == 0);
            applyStimulus(($urandom_range(3) != 0), 2'($urandom_range(3)), ful, emp, rd,
                          ($urandom_range(3) == 0), ($urandom_range(3) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
